// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - eight-digit multiplexed BCD seven-segment scanner; optional leading-zero blanking under SEG7_LZB_EN
module seg7_scan #(
   parameter int SCAN_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] bcd,
   input  logic        load,
   output logic [6:0]  seg,
   output logic [7:0]  an,
   output logic        frame_done
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam logic [PW-1:0] PCNT_MAX = PW'(SCAN_DIV - 1);

   logic [PW-1:0] pcnt;
   logic [2:0]    didx;
   logic [31:0]   hold;
   logic [31:0]   shadow;
   logic          pending;
   logic          tick;
   logic          wrap;
   logic [3:0]    nib;
   logic [6:0]    seg_next;
   logic [7:0]    an_next;

   // Active-low segment pattern {g,f,e,d,c,b,a}; A..F show a lone dash.
   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h3F;
      endcase
      return s;
   endfunction

   assign tick = (pcnt == PCNT_MAX);
   assign wrap = tick && (didx == 3'd7);

   // Prescaler: one tick every SCAN_DIV cycles.
   always_ff @(posedge clk) begin
      if (rst)
         pcnt <= '0;
      else if (tick)
         pcnt <= '0;
      else
         pcnt <= pcnt + PW'(1);
   end

   // Digit index steps once per tick and wraps naturally 7 -> 0.
   always_ff @(posedge clk) begin
      if (rst)
         didx <= 3'd0;
      else if (tick)
         didx <= didx + 3'd1;
   end

   // Double buffer: new values wait in hold and move to shadow only at a frame wrap, so a frame never mixes two values.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold    <= '0;
         shadow  <= '0;
         pending <= 1'b0;
      end else if (load) begin
         hold <= bcd;
         if (wrap) begin
            shadow  <= bcd;
            pending <= 1'b0;
         end else begin
            pending <= 1'b1;
         end
      end else if (wrap && pending) begin
         shadow  <= hold;
         pending <= 1'b0;
      end
   end

   // Select the nibble for the current digit and form the next output pattern.
   always_comb begin
      nib      = shadow[{didx, 2'b00} +: 4];
      an_next  = ~(8'h01 << didx);
      seg_next = decode(nib);
`ifdef SEG7_LZB_EN
      if ((didx != 3'd0) && ((shadow >> {didx, 2'b00}) == 32'd0))
         seg_next = 7'h7F;
`endif
   end

   // Registered outputs; frame_done marks the cycle after the last digit's tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         an         <= 8'hFF;
         seg        <= 7'h7F;
         frame_done <= 1'b0;
      end else begin
         an         <= an_next;
         seg        <= seg_next;
         frame_done <= wrap;
      end
   end

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - self-checking bench for seg7_scan with a frame-level reference model
module tb_seg7_scan;

   localparam int SD    = 4;
   localparam int FRAME = 8 * SD;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] bcd = '0;
   logic        load = 1'b0;
   logic [6:0]  seg;
   logic [7:0]  an;
   logic        frame_done;

   int checks = 0;
   int failures = 0;

   int          mk = 0;
   logic [31:0] m_hold = '0;
   logic [31:0] m_shadow = '0;
   bit          m_pend = 0;
   logic [7:0]  e_an;
   logic [6:0]  e_seg;
   logic        e_fd;
   logic [6:0]  seg_obs [8];
   int          fd_first;
   int          fd_second;

   seg7_scan #(.SCAN_DIV(SD)) dut (
      .clk(clk), .rst(rst), .bcd(bcd), .load(load),
      .seg(seg), .an(an), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [6:0] ref_seg(input logic [31:0] v, input int d);
      int msd;
      logic [3:0] n;
      msd = 0;
      for (int i = 0; i < 8; i++)
         if (((v / (32'd1 << (4 * i))) % 16) != 0) msd = i;
      n = 4'((v / (32'd1 << (4 * d))) % 16);
`ifdef SEG7_LZB_EN
      if (d > msd) return 7'h7F;
`endif
      case (n)
         4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;  4'd3: return 7'h30;
         4'd4: return 7'h19;  4'd5: return 7'h12;  4'd6: return 7'h02;  4'd7: return 7'h78;
         4'd8: return 7'h00;  4'd9: return 7'h10;
         default: return 7'h3F;
      endcase
   endfunction

   // Advance one clock: update the model from the current inputs, then compare every output.
   task automatic step();
      int pos;
      int d;
      bit wr;
      if (rst) begin
         mk = 0; m_hold = '0; m_shadow = '0; m_pend = 0;
         e_an = 8'hFF; e_seg = 7'h7F; e_fd = 1'b0;
      end else begin
         pos = mk % FRAME;
         d   = pos / SD;
         wr  = (pos == FRAME - 1);
         e_an  = ~(8'h01 << d);
         e_seg = ref_seg(m_shadow, d);
         e_fd  = wr;
         if (load) begin
            m_hold = bcd;
            if (wr) begin m_shadow = bcd; m_pend = 0; end
            else m_pend = 1;
         end else if (wr && m_pend) begin
            m_shadow = m_hold; m_pend = 0;
         end
         mk++;
      end
      @(posedge clk);
      #1;
      check("an", 32'(an), 32'(e_an));
      check("seg", 32'(seg), 32'(e_seg));
      check("frame_done", 32'(frame_done), 32'(e_fd));
   endtask

   task automatic pulse_load(input logic [31:0] v);
      bcd = v; load = 1'b1;
      step();
      load = 1'b0;
   endtask

   task automatic advance_to(input int p);
      for (int i = 0; i < FRAME + 2 && (mk % FRAME) != p; i++) step();
      check("align", 32'(mk % FRAME), 32'(p));
   endtask

   task automatic capture_frame();
      for (int i = 0; i < 8; i++) seg_obs[i] = 7'h55;
      for (int c = 0; c < FRAME; c++) begin
         step();
         for (int i = 0; i < 8; i++)
            if (an[i] == 1'b0) seg_obs[i] = seg;
      end
   endtask

   initial begin
      // Reset held three cycles.
      rst = 1'b1;
      step(); step(); step();
      check("rst_an", 32'(an), 32'h FF);
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_fd", 32'(frame_done), 32'h0);

      // First edge after release.
      rst = 1'b0;
      step();
      check("rel_an", 32'(an), 32'hFE);
      check("rel_seg", 32'(seg), 32'h40);

      // frame_done period.
      fd_first = -1; fd_second = -1;
      for (int c = 0; c < 3 * FRAME && fd_second < 0; c++) begin
         step();
         if (frame_done) begin
            if (fd_first < 0) fd_first = c; else fd_second = c;
         end
      end
      check("fd_period", 32'(fd_second - fd_first), 32'(FRAME));

      // Mid-frame load is deferred to the next frame.
      advance_to(10);
      pulse_load(32'h12345678);
      advance_to(0);
      capture_frame();
      check("f1_d0", 32'(seg_obs[0]), 32'h00);
      check("f1_d7", 32'(seg_obs[7]), 32'h79);

      // Hex nibbles shown as dash.
      advance_to(5);
      pulse_load(32'h0000A0F9);
      advance_to(0);
      capture_frame();
      check("hex_d0", 32'(seg_obs[0]), 32'h10);
      check("hex_d1", 32'(seg_obs[1]), 32'h3F);
      check("hex_d3", 32'(seg_obs[3]), 32'h3F);

      // Leading zeros, with a repeated load keeping only the last value.
      advance_to(3);
      pulse_load(32'h87654321);
      step();
      pulse_load(32'h00000105);
      advance_to(0);
      capture_frame();
      check("lz_d2", 32'(seg_obs[2]), 32'h79);
      for (int i = 3; i < 8; i++) begin
`ifdef SEG7_LZB_EN
         check("lz_hi", 32'(seg_obs[i]), 32'h7F);
`else
         check("lz_hi", 32'(seg_obs[i]), 32'h40);
`endif
      end

      // Load coinciding with the wrap tick lands in the very next frame.
      advance_to(FRAME - 1);
      pulse_load(32'h00000009);
      capture_frame();
      check("wrap_d0", 32'(seg_obs[0]), 32'h10);

      // Randomised loads and occasional reset against the model.
      for (int c = 0; c < 600; c++) begin
         rst  = ($urandom_range(0, 199) == 0);
         load = ($urandom_range(0, 7) == 0);
         bcd  = $urandom >> (4 * $urandom_range(0, 7));
         step();
      end
      rst = 1'b0; load = 1'b0;

      // Reset during digit 5 with a load pending.
      advance_to(0);
      advance_to(14);
      pulse_load(32'h99999999);
      advance_to(5 * SD);
      rst = 1'b1;
      step();
      check("mid_rst_an", 32'(an), 32'hFF);
      check("mid_rst_seg", 32'(seg), 32'h7F);
      rst = 1'b0;
      step();
      check("post_an", 32'(an), 32'hFE);
      check("post_seg", 32'(seg), 32'h40);
      advance_to(0);
      capture_frame();
      check("post_d0", 32'(seg_obs[0]), 32'h40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
